// File: rtl/add_sched.sv
// add_sched: round-robin scheduler sharing one fixed-point add unit among
// NUM_REQ requesters. Each cycle it grants at most one request and registers
// that request's operands onto the add inputs. It follows each issued
// operation through the adder latency with a tag pipeline, then returns the
// result tagged with the owning requester ID.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_valid_i          per-requester request valid
//   req_ready_o          per-requester grant (one-hot or zero)
//   req_in0_i/in1_i/u_i  packed operands, requester i at [i*W +: W]
//   req_s_add_i          per-requester mode bit
//   add_in0_o/in1_o/u_o  registered operands to the shared add
//   add_s_add_o          registered mode bit to the shared add
//   add_out0_i/out1_i    results from the shared add
//   rsp_valid_o          one-cycle response strobe
//   rsp_id_o             requester that owns the response
//   rsp_out0_o/out1_o    registered copies of the add results
module add_sched #(
    parameter int NUM_REQ         = 4,
    parameter int FIX_POINT_WIDTH = 16,
    parameter int ADD_LAT         = 1,
    parameter int ID_W            = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ*FIX_POINT_WIDTH-1:0] req_in0_i,
    input  logic [NUM_REQ*FIX_POINT_WIDTH-1:0] req_in1_i,
    input  logic [NUM_REQ*FIX_POINT_WIDTH-1:0] req_u_i,
    input  logic [NUM_REQ-1:0]                 req_s_add_i,
    output logic [FIX_POINT_WIDTH-1:0]         add_in0_o,
    output logic [FIX_POINT_WIDTH-1:0]         add_in1_o,
    output logic [FIX_POINT_WIDTH-1:0]         add_u_o,
    output logic                               add_s_add_o,
    input  logic [FIX_POINT_WIDTH-1:0]         add_out0_i,
    input  logic [FIX_POINT_WIDTH-1:0]         add_out1_i,
    output logic                               rsp_valid_o,
    output logic [ID_W-1:0]                    rsp_id_o,
    output logic [FIX_POINT_WIDTH-1:0]         rsp_out0_o,
    output logic [FIX_POINT_WIDTH-1:0]         rsp_out1_o
);

    localparam int W = FIX_POINT_WIDTH;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantId;
    logic               found;
    logic               handshake;
    int                 idx;
    logic [ID_W-1:0]    idxId;

    logic [W-1:0] in0Arr [NUM_REQ];
    logic [W-1:0] in1Arr [NUM_REQ];
    logic [W-1:0] uArr   [NUM_REQ];

    logic [W-1:0] add_in0_q, add_in0_d;
    logic [W-1:0] add_in1_q, add_in1_d;
    logic [W-1:0] add_u_q, add_u_d;
    logic         add_s_add_q, add_s_add_d;

    // Stage j holds the token for the operation whose add inputs were loaded
    // j cycles ago; stage ADD_LAT lines up with add_out holding its result.
    logic [ADD_LAT:0] tagValid_q;
    logic [ID_W-1:0]  tagId_q [ADD_LAT+1];

    logic         rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [W-1:0] rsp_out0_q, rsp_out1_q;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign in0Arr[g] = req_in0_i[g*W +: W];
            assign in1Arr[g] = req_in1_i[g*W +: W];
            assign uArr[g]   = req_u_i[g*W +: W];
        end
    endgenerate

    // Search starts at the priority pointer and wraps modulo NUM_REQ; the
    // first valid requester found wins. No grant is offered during reset.
    always_comb begin
        grant   = '0;
        grantId = '0;
        found   = 1'b0;
        idx     = 0;
        idxId   = '0;
        if (!rst_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx   = (int'(ptr_q) + k) % NUM_REQ;
                idxId = ID_W'(idx);
                if (!found && req_valid_i[idxId]) begin
                    grant[idxId] = 1'b1;
                    grantId      = idxId;
                    found        = 1'b1;
                end
            end
        end
    end

    assign handshake   = |(grant & req_valid_i);
    assign req_ready_o = grant;

    // After a grant the pointer moves just past the winner so it becomes
    // lowest priority next time.
    always_comb begin
        ptr_d       = ptr_q;
        add_in0_d   = add_in0_q;
        add_in1_d   = add_in1_q;
        add_u_d     = add_u_q;
        add_s_add_d = add_s_add_q;
        if (handshake) begin
            ptr_d       = (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + ID_W'(1);
            add_in0_d   = in0Arr[grantId];
            add_in1_d   = in1Arr[grantId];
            add_u_d     = uArr[grantId];
            add_s_add_d = req_s_add_i[grantId];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            add_in0_q   <= '0;
            add_in1_q   <= '0;
            add_u_q     <= '0;
            add_s_add_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            add_in0_q   <= add_in0_d;
            add_in1_q   <= add_in1_d;
            add_u_q     <= add_u_d;
            add_s_add_q <= add_s_add_d;
        end
    end

    // Reset clears every token so operations in flight never respond.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tagValid_q <= '0;
            for (int j = 0; j <= ADD_LAT; j++) begin
                tagId_q[j] <= '0;
            end
        end else begin
            tagValid_q[0] <= handshake;
            tagId_q[0]    <= grantId;
            for (int j = 1; j <= ADD_LAT; j++) begin
                tagValid_q[j] <= tagValid_q[j-1];
                tagId_q[j]    <= tagId_q[j-1];
            end
        end
    end

    // Data outputs only update for a valid token and hold otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out0_q  <= '0;
            rsp_out1_q  <= '0;
        end else begin
            rsp_valid_q <= tagValid_q[ADD_LAT];
            if (tagValid_q[ADD_LAT]) begin
                rsp_id_q   <= tagId_q[ADD_LAT];
                rsp_out0_q <= add_out0_i;
                rsp_out1_q <= add_out1_i;
            end
        end
    end

    assign add_in0_o   = add_in0_q;
    assign add_in1_o   = add_in1_q;
    assign add_u_o     = add_u_q;
    assign add_s_add_o = add_s_add_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_out0_o  = rsp_out0_q;
    assign rsp_out1_o  = rsp_out1_q;

endmodule

// File: tb/tb_add_sched.sv
// tb_add_sched: directed bench for add_sched with NUM_REQ=4, W=16, ADD_LAT=1.
// Drives requests, expects grants, and keeps a queue of expected responses.
// A 1-cycle registered add model (out0 = in0 + in1, out1 = u) closes the loop.
module tb_add_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  reqValid;
    logic [3:0]  reqReady;
    logic [63:0] reqIn0, reqIn1, reqU;
    logic [3:0]  reqSAdd;
    logic [15:0] addIn0, addIn1, addU;
    logic        addSAdd;
    logic [15:0] addOut0, addOut1;
    logic        rspValid;
    logic [1:0]  rspId;
    logic [15:0] rspOut0, rspOut1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] in0Of [4];
    logic [15:0] in1Of [4];
    logic [15:0] uOf   [4];

    typedef struct {
        logic [1:0]  id;
        logic [15:0] out0;
        logic [15:0] out1;
        int          cyc;
    } expT;
    expT sb[$];

    logic [15:0] lastOut0 = '0;
    logic [15:0] lastOut1 = '0;

    add_sched #(
        .NUM_REQ(4), .FIX_POINT_WIDTH(16), .ADD_LAT(1), .ID_W(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_in0_i(reqIn0), .req_in1_i(reqIn1), .req_u_i(reqU),
        .req_s_add_i(reqSAdd),
        .add_in0_o(addIn0), .add_in1_o(addIn1), .add_u_o(addU),
        .add_s_add_o(addSAdd),
        .add_out0_i(addOut0), .add_out1_i(addOut1),
        .rsp_valid_o(rspValid), .rsp_id_o(rspId),
        .rsp_out0_o(rspOut0), .rsp_out1_o(rspOut1)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter advances on every rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Shared add unit model: one register stage.
    always @(posedge clk) begin
        addOut0 <= addIn0 + addIn1;
        addOut1 <= addU;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive the given valids, check the combinational grant, record the
    // response the expected winner must produce, then advance one cycle.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] expGrant, input string tag);
        expT e;
        reqValid = valid;
        for (int i = 0; i < 4; i++) begin
            reqIn0[i*16 +: 16] = in0Of[i];
            reqIn1[i*16 +: 16] = in1Of[i];
            reqU[i*16 +: 16]   = uOf[i];
        end
        #1;
        checkOutput(tag, {28'd0, reqReady}, {28'd0, expGrant});
        for (int i = 0; i < 4; i++) begin
            if (expGrant[i]) begin
                e.id   = 2'(i);
                e.out0 = in0Of[i] + in1Of[i];
                e.out1 = uOf[i];
                e.cyc  = cyc + 3;
                sb.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    // Response monitor: a response is required exactly in the cycle it is
    // due; in every other cycle rsp_valid is low and the data holds.
    always begin
        expT e;
        @(negedge clk);
        #3;
        if (rst) begin
            lastOut0 = '0;
            lastOut1 = '0;
        end else begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checkOutput("rsp_valid", {31'd0, rspValid}, 32'd1);
                checkOutput("rsp_id", {30'd0, rspId}, {30'd0, e.id});
                checkOutput("rsp_out0", {16'd0, rspOut0}, {16'd0, e.out0});
                checkOutput("rsp_out1", {16'd0, rspOut1}, {16'd0, e.out1});
            end else begin
                checkOutput("rsp_idle", {31'd0, rspValid}, 32'd0);
                checkOutput("rsp_hold0", {16'd0, rspOut0}, {16'd0, lastOut0});
                checkOutput("rsp_hold1", {16'd0, rspOut1}, {16'd0, lastOut1});
            end
            lastOut0 = rspOut0;
            lastOut1 = rspOut1;
        end
    end

    initial begin
        rst      = 1'b1;
        reqValid = 4'b1111;
        reqIn0   = '0;
        reqIn1   = '0;
        reqU     = '0;
        reqSAdd  = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            in0Of[i] = 16'(i);
            in1Of[i] = 16'd10;
            uOf[i]   = 16'(100 + i);
        end

        // Reset: no grant while reset is high, registers cleared.
        @(negedge clk);
        #1;
        checkOutput("ready_in_reset", {28'd0, reqReady}, 32'd0);
        @(negedge clk);
        checkOutput("rst_add_in0", {16'd0, addIn0}, 32'd0);
        checkOutput("rst_add_s_add", {31'd0, addSAdd}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("rst_rsp_out0", {16'd0, rspOut0}, 32'd0);
        checkOutput("rst_ptr", {30'd0, dut.ptr_q}, 32'd0);
        rst = 1'b0;

        // Single request from requester 1.
        $display("[TB] single request");
        in0Of[1] = 16'd1;
        in1Of[1] = 16'd2;
        uOf[1]   = 16'd5;
        applyStimulus(4'b0010, 4'b0010, "grant_single");
        checkOutput("issue_in0", {16'd0, addIn0}, 32'd1);
        checkOutput("issue_in1", {16'd0, addIn1}, 32'd2);
        checkOutput("issue_u", {16'd0, addU}, 32'd5);
        checkOutput("issue_s_add", {31'd0, addSAdd}, 32'd1);
        checkOutput("ptr_single", {30'd0, dut.ptr_q}, 32'd2);
        applyStimulus(4'b0000, 4'b0000, "idle");
        applyStimulus(4'b0000, 4'b0000, "idle");
        applyStimulus(4'b0000, 4'b0000, "idle");

        // Requester 3 alone moves the pointer back to 0.
        in0Of[1] = 16'd1;
        in1Of[1] = 16'd10;
        uOf[1]   = 16'd101;
        reqSAdd  = 4'b0000;
        applyStimulus(4'b1000, 4'b1000, "grant_lone3");

        // All four valid: strict rotation, back-to-back responses.
        $display("[TB] full rotation");
        for (int n = 0; n < 8; n++) begin
            logic [3:0] g;
            g = 4'b0001 << (n % 4);
            applyStimulus(4'b1111, g, "grant_rotate");
        end
        applyStimulus(4'b0000, 4'b0000, "idle");

        // Wrap and skip with only requesters 0 and 2.
        $display("[TB] wrap and skip");
        applyStimulus(4'b0100, 4'b0100, "grant_lone2");
        applyStimulus(4'b0101, 4'b0001, "grant_wrap0");
        applyStimulus(4'b0101, 4'b0100, "grant_skip2");
        applyStimulus(4'b0000, 4'b0000, "idle");
        checkOutput("ptr_wrap", {30'd0, dut.ptr_q}, 32'd3);
        applyStimulus(4'b0000, 4'b0000, "idle");
        applyStimulus(4'b0000, 4'b0000, "idle");

        // Idle gaps: two handshakes two cycles apart.
        $display("[TB] idle gaps");
        in0Of[0] = 16'd7;
        uOf[0]   = 16'h1234;
        applyStimulus(4'b0001, 4'b0001, "grant_gap_a");
        applyStimulus(4'b0000, 4'b0000, "idle");
        in0Of[0] = 16'd20;
        uOf[0]   = 16'h4321;
        applyStimulus(4'b0001, 4'b0001, "grant_gap_b");
        for (int n = 0; n < 4; n++) applyStimulus(4'b0000, 4'b0000, "idle");

        // Reset mid-flight discards both in-flight operations.
        $display("[TB] reset mid-flight");
        applyStimulus(4'b0010, 4'b0010, "grant_pre_rst1");
        applyStimulus(4'b0100, 4'b0100, "grant_pre_rst2");
        rst      = 1'b1;
        reqValid = 4'b1111;
        sb.delete();
        #1;
        checkOutput("ready_mid_reset", {28'd0, reqReady}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("post_rst_add_in0", {16'd0, addIn0}, 32'd0);
        checkOutput("post_rst_add_in1", {16'd0, addIn1}, 32'd0);
        checkOutput("post_rst_add_u", {16'd0, addU}, 32'd0);
        checkOutput("post_rst_rsp_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("post_rst_rsp_id", {30'd0, rspId}, 32'd0);
        checkOutput("post_rst_rsp_out0", {16'd0, rspOut0}, 32'd0);
        checkOutput("post_rst_rsp_out1", {16'd0, rspOut1}, 32'd0);
        applyStimulus(4'b1001, 4'b0001, "grant_after_rst");
        for (int n = 0; n < 4; n++) applyStimulus(4'b0000, 4'b0000, "idle");

        // Early withdraw: requester 2 drops before it is granted.
        $display("[TB] early withdraw");
        applyStimulus(4'b1000, 4'b1000, "grant_lone3b");
        applyStimulus(4'b0101, 4'b0001, "grant_withdraw");
        applyStimulus(4'b0000, 4'b0000, "idle");
        checkOutput("ptr_withdraw", {30'd0, dut.ptr_q}, 32'd1);
        for (int n = 0; n < 5; n++) applyStimulus(4'b0000, 4'b0000, "idle");

        checkOutput("drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_sched.md
# add_sched

Round-robin scheduler that shares one fixed-point `add` datapath instance among `NUM_REQ` requesters in the nonlinear-function pipeline.
- Grants at most one request per cycle and registers the winner's operands onto the `add` inputs.
- Tracks each in-flight operation through the adder's latency and returns `out0`/`out1` tagged with the requester ID.
- Sits between the function-evaluation engines (requesters) and the single shared `add` unit.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters (2..8).
- `FIX_POINT_WIDTH`, 16 — operand/result width W.
- `ADD_LAT`, 1 — register stages inside the attached `add` unit (0 = combinational).
- `ID_W`, 2 — width of requester ID; equals clog2(`NUM_REQ`).

Ports:
- `clk`  in  1  — single clock; everything is on the rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ  — per-requester request valid.
- `req_ready`  out  NUM_REQ  — per-requester grant, one-hot or zero.
- `req_in0`  in  NUM_REQ*W  — packed operand in0; requester i occupies bits [i*W +: W].
- `req_in1`  in  NUM_REQ*W  — packed operand in1, same packing.
- `req_u`  in  NUM_REQ*W  — packed operand u, same packing.
- `req_s_add`  in  NUM_REQ  — per-requester s_add mode bit.
- `add_in0`, `add_in1`, `add_u`  out  W each  — registered operands driven to the shared `add`.
- `add_s_add`  out  1  — registered mode bit to `add`.
- `add_out0`, `add_out1`  in  W each  — results returned from `add`.
- `rsp_valid`  out  1  — response valid, one cycle per accepted request.
- `rsp_id`  out  ID_W  — requester that owns the response.
- `rsp_out0`, `rsp_out1`  out  W each  — registered copies of `add_out0` / `add_out1`.

## Operation
Arbitration:
- Priority pointer `ptr` (ID_W bits); reset value 0.
- Grant goes to the first i with `req_valid[i]`=1, searching i = ptr, ptr+1, … modulo `NUM_REQ`.
- `req_ready` is combinational from `req_valid` and `ptr`.
  - Exactly one bit is high when any valid is high; all zero otherwise.
  - Forced to 0 while `rst`=1.
- Handshake happens when `req_valid[i]` & `req_ready[i]` are both 1.
  - On a handshake, `ptr` <= i+1 modulo `NUM_REQ`.
  - With no handshake, `ptr` holds.
- Requesters keep operands stable while `req_valid`=1. Dropping `req_valid` before it is granted is legal; no operation is issued for it.

Issue:
- On a handshake, the winner's in0/in1/u/s_add are loaded into the `add_*` registers.
- Those registers hold their last value when there is no handshake; the adder's output is ignored in that case.

Tag pipeline:
- A (valid, id) token enters a shift pipeline on each handshake; a bubble (valid=0) enters otherwise.
- Pipeline depth is `ADD_LAT`+1, aligned so the token reaches the capture stage in the same cycle that `add_out*` holds its result.

Response:
- When the capture-stage token is valid, `rsp_out0`/`rsp_out1`/`rsp_id` are loaded and `rsp_valid` is set to 1 for one cycle; otherwise `rsp_valid`=0 and the data outputs hold.
- The response channel has no backpressure. Throughput is one issue and one response per cycle.
- Responses come back in issue order.

Reset values:
- `add_in0`, `add_in1`, `add_u`, `add_s_add` = 0.
- `rsp_valid` = 0, `rsp_id` = 0, `rsp_out0` = 0, `rsp_out1` = 0.
- All tag-pipeline tokens invalid; `ptr` = 0.

## Timing
- Handshake in cycle t → `add_*` operands visible in cycle t+1.
- `add_out*` is valid in cycle t+1+`ADD_LAT`.
- `rsp_valid`=1 in cycle t+2+`ADD_LAT`. Total latency is `ADD_LAT`+2 cycles (3 at the default).
- Back-to-back handshakes in cycles t and t+1 give responses in consecutive cycles.
- Boundary conditions:
  - `ptr` wraps from `NUM_REQ`-1 to 0.
  - A lone requester is granted every cycle it is valid.
  - When all requesters are valid, grants strictly rotate 0,1,2,3,0,…
- Reset asserted mid-operation:
  - All in-flight tokens are discarded, so no response appears for operations accepted before reset.
  - `req_ready`=0 in every cycle `rst`=1.
  - First grant is possible in the cycle after `rst` falls, starting at `ptr`=0.

## Test plan
All scenarios use `NUM_REQ`=4, W=16, `ADD_LAT`=1. The bench-side `add` model is 1-cycle registered with out0=in0+in1 and out1=u.

- Single request: req1 sends in0=1, in1=2, u=5 with `req_ready[1]` in cycle t → `rsp_valid`=1 in t+3 with `rsp_id`=1, `rsp_out0`=3, `rsp_out1`=5; `ptr`=2.
- All four requesters valid for 8 cycles, requester i sending in0=i, in1=10 → grant order 0,1,2,3,0,1,2,3; 8 consecutive responses with ids in that order and out0 = 10,11,12,13,10,11,12,13.
- Wrap and skip: `ptr`=3 with only req0 and req2 valid → req0 granted, then req2; `ptr` ends at 3.
- Idle gaps: handshakes in cycles 5 and 7 only → `rsp_valid` high in cycles 8 and 10 only, with `rsp_out*` holding in cycle 9.
- Reset mid-flight: handshakes in cycles 4 and 5, `rst`=1 in cycle 6 → no response ever appears for either request; all outputs 0 in cycle 7; a new request in cycle 7 responds in cycle 10 with the correct id.
- Early withdraw: req2 valid for one cycle while req0 is granted, then deasserted → no response for req2 and `ptr` stays at 1.
